// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// States follow the frame layout: length bytes, data bytes, checksum, then a terminal state.
package imem_loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [2:0] {
      LD_LEN_HI,
      LD_LEN_LO,
      LD_DATA,
      LD_CHECK,
      LD_DONE,
      LD_ERR
   } ldState_e;

   // True while the loader still consumes frame bytes.
   function automatic logic isReceiving(input ldState_e s);
      return (s != LD_DONE) && (s != LD_ERR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader; the master side feeds bytes and observes imem writes.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic [BYTE_W-1:0] ByteIn;
   logic              ByteValid;
   logic              ByteReady;
   logic              ImemWrEn;
   logic [ADDR_W-1:0] ImemAddr;
   logic [WORD_W-1:0] ImemWrData;

   modport master (
      output ByteIn, ByteValid,
      input  ByteReady, ImemWrEn, ImemAddr, ImemWrData
   );

   modport slave (
      input  ByteIn, ByteValid,
      output ByteReady, ImemWrEn, ImemAddr, ImemWrData
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes MSB-first into a 32-bit word and pulses wordValid
// the cycle after the fourth byte. A clear discards any partial word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clear,
   input  logic              byteEn,
   input  logic [BYTE_W-1:0] byteIn,
   output logic              laneLast_c,
   output logic [WORD_W-1:0] word,
   output logic              wordValid
);

   logic [LANE_W-1:0]        lane;
   logic [WORD_W-BYTE_W-1:0] shiftReg;

   assign laneLast_c = (lane == LANE_W'(3));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lane      <= '0;
         shiftReg  <= '0;
         word      <= '0;
         wordValid <= 1'b0;
      end else if (clear) begin
         lane      <= '0;
         shiftReg  <= '0;
         wordValid <= 1'b0;
      end else begin
         wordValid <= byteEn & laneLast_c;
         if (byteEn) begin
            lane     <= lane + LANE_W'(1);
            shiftReg <= {shiftReg[WORD_W-2*BYTE_W-1:0], byteIn};
            if (laneLast_c) word <= {shiftReg, byteIn};
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte image, writes it to instruction
// memory from BASE_ADDR up, and releases the core only once the checksum matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned       IMEM_WORDS = 128,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Reload,
   imem_loader_if.slave  bus,
   output logic          CpuHold,
   output logic          Done,
   output logic          Error
);

   ldState_e          state, stateNext;
   logic              byteReadyNext, cpuHoldNext, doneNext, errorNext;
   logic [BYTE_W-1:0] lenHi, xorAcc;
   logic [CNT_W-1:0]  wordCount, wordIdx, lenWord;
   logic              accept, dataByte, reloadOk, lastWord, laneLast;

   assign accept   = bus.ByteValid & bus.ByteReady;
   assign dataByte = accept && (state == LD_DATA);
   assign reloadOk = Reload && !isReceiving(state);
   assign lenWord  = {lenHi, bus.ByteIn};
   assign lastWord = ((wordIdx + CNT_W'(1)) == wordCount);

   imem_loader_byte_packer u_packer (
      .Clk        (Clk),
      .Reset      (Reset),
      .clear      (reloadOk),
      .byteEn     (dataByte),
      .byteIn     (bus.ByteIn),
      .laneLast_c (laneLast),
      .word       (bus.ImemWrData),
      .wordValid  (bus.ImemWrEn)
   );

   // State register; Moore outputs are registered alongside it from the next state.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state         <= LD_LEN_HI;
         bus.ByteReady <= 1'b1;
         CpuHold       <= 1'b1;
         Done          <= 1'b0;
         Error         <= 1'b0;
      end else begin
         state         <= stateNext;
         bus.ByteReady <= byteReadyNext;
         CpuHold       <= cpuHoldNext;
         Done          <= doneNext;
         Error         <= errorNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         LD_LEN_HI: if (accept) stateNext = LD_LEN_LO;
         LD_LEN_LO: begin
            if (accept) begin
               if (lenWord == '0)                     stateNext = LD_CHECK;
               else if (32'(lenWord) > IMEM_WORDS)    stateNext = LD_ERR;
               else                                   stateNext = LD_DATA;
            end
         end
         LD_DATA:   if (accept && laneLast && lastWord) stateNext = LD_CHECK;
         LD_CHECK:  if (accept) stateNext = (bus.ByteIn == xorAcc) ? LD_DONE : LD_ERR;
         LD_DONE,
         LD_ERR:    if (Reload) stateNext = LD_LEN_HI;
         default:   stateNext = LD_LEN_HI;
      endcase
   end

   always_comb begin
      byteReadyNext = 1'b1;
      cpuHoldNext   = 1'b1;
      doneNext      = 1'b0;
      errorNext     = 1'b0;
      case (stateNext)
         LD_DONE: begin
            byteReadyNext = 1'b0;
            cpuHoldNext   = 1'b0;
            doneNext      = 1'b1;
         end
         LD_ERR: begin
            byteReadyNext = 1'b0;
            errorNext     = 1'b1;
         end
         default: ;
      endcase
   end

   // Length capture, word index, checksum accumulator and write address.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lenHi        <= '0;
         wordCount    <= '0;
         wordIdx      <= '0;
         xorAcc       <= '0;
         bus.ImemAddr <= BASE_ADDR;
      end else if (reloadOk) begin
         wordIdx <= '0;
         xorAcc  <= '0;
      end else begin
         if (accept && (state == LD_LEN_HI)) lenHi     <= bus.ByteIn;
         if (accept && (state == LD_LEN_LO)) wordCount <= lenWord;
         if (dataByte) begin
            xorAcc <= xorAcc ^ bus.ByteIn;
            if (laneLast) begin
               bus.ImemAddr <= BASE_ADDR + ADDR_W'({wordIdx, 2'b00});
               wordIdx      <= wordIdx + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum/length errors, reload, gaps, mid-word reset.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic Reload = 1'b0;
   logic CpuHold, Done, Error;

   imem_loader_if bus();

   imem_loader #(.IMEM_WORDS(128), .BASE_ADDR(32'h0)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Reload  (Reload),
      .bus     (bus),
      .CpuHold (CpuHold),
      .Done    (Done),
      .Error   (Error)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;
   logic [31:0] wrAddr[$];
   logic [31:0] wrData[$];
   logic [7:0]  frame[$];

   always @(negedge Clk) begin
      if (bus.ImemWrEn === 1'b1) begin
         wrAddr.push_back(bus.ImemAddr);
         wrData.push_back(bus.ImemWrData);
      end
   end

   task automatic sendByte(input logic [7:0] b, input int gap);
      int n;
      bus.ByteValid = 1'b0;
      repeat (gap) @(negedge Clk);
      @(negedge Clk);
      bus.ByteIn    = b;
      bus.ByteValid = 1'b1;
      n = 0;
      while (bus.ByteReady !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 20) begin
         tests++; fails++;
         $display("FAIL byte_accept_timeout: ByteReady=%b required 1", bus.ByteReady);
      end
      @(posedge Clk);
      #1 bus.ByteValid = 1'b0;
   endtask

   task automatic sendFrame(input int maxGap);
      foreach (frame[i]) sendByte(frame[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
   endtask

   // Good two-word frame; checksum is the XOR of the eight data bytes (0x55).
   task automatic loadGoodFrame(input logic [7:0] csum);
      frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, csum};
   endtask

   task automatic doReload();
      @(negedge Clk);
      Reload = 1'b1;
      @(posedge Clk);
      #1 Reload = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (bus.ByteReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.ByteReady); end
      tests++; if (bus.ImemWrEn !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b want 0", bus.ImemWrEn); end
      tests++; if (bus.ImemAddr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.ImemAddr); end
      tests++; if (bus.ImemWrData !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.ImemWrData); end
      tests++; if (CpuHold !== 1'b1) begin fails++; $display("FAIL reset_hold: got %b want 1", CpuHold); end
      tests++; if (Done !== 1'b0 || Error !== 1'b0) begin fails++; $display("FAIL reset_flags: Done=%b Error=%b want 0 0", Done, Error); end
   endtask

   task automatic test_good_frame(input string tag, input int maxGap);
      wrAddr.delete(); wrData.delete();
      loadGoodFrame(8'h55);
      sendFrame(maxGap);
      repeat (2) @(negedge Clk);
      tests++; if (wrAddr.size() != 2) begin fails++; $display("FAIL %s_wrcount: got %0d want 2", tag, wrAddr.size()); end
      else begin
         tests++; if (wrAddr[0] !== 32'h0 || wrData[0] !== 32'h20080005) begin fails++;
            $display("FAIL %s_word0: got %h@%h want 20080005@00000000", tag, wrData[0], wrAddr[0]); end
         tests++; if (wrAddr[1] !== 32'h4 || wrData[1] !== 32'h01095020) begin fails++;
            $display("FAIL %s_word1: got %h@%h want 01095020@00000004", tag, wrData[1], wrAddr[1]); end
      end
      tests++; if (Done !== 1'b1 || CpuHold !== 1'b0 || Error !== 1'b0) begin fails++;
         $display("FAIL %s_flags: Done=%b CpuHold=%b Error=%b want 1 0 0", tag, Done, CpuHold, Error); end
      tests++; if (bus.ByteReady !== 1'b0) begin fails++; $display("FAIL %s_ready: got %b want 0", tag, bus.ByteReady); end
   endtask

   task automatic test_bad_checksum();
      doReload();
      wrAddr.delete(); wrData.delete();
      loadGoodFrame(8'h71);
      sendFrame(0);
      repeat (2) @(negedge Clk);
      tests++; if (wrAddr.size() != 2) begin fails++; $display("FAIL badsum_wrcount: got %0d want 2", wrAddr.size()); end
      tests++; if (Error !== 1'b1 || CpuHold !== 1'b1 || Done !== 1'b0) begin fails++;
         $display("FAIL badsum_flags: Error=%b CpuHold=%b Done=%b want 1 1 0", Error, CpuHold, Done); end
   endtask

   task automatic test_length_overflow();
      doReload();
      wrAddr.delete(); wrData.delete();
      sendByte(8'h00, 0);
      sendByte(8'h81, 0);
      tests++; if (Error !== 1'b1 || Done !== 1'b0) begin fails++; $display("FAIL len129_flags: Error=%b Done=%b want 1 0", Error, Done); end
      tests++; if (bus.ByteReady !== 1'b0) begin fails++; $display("FAIL len129_ready: got %b want 0", bus.ByteReady); end
      repeat (3) @(negedge Clk);
      tests++; if (wrAddr.size() != 0) begin fails++; $display("FAIL len129_writes: got %0d want 0", wrAddr.size()); end
      doReload();
      sendByte(8'h01, 0);
      sendByte(8'h00, 0);
      tests++; if (Error !== 1'b1) begin fails++; $display("FAIL len256_error: got %b want 1", Error); end
   endtask

   // Length exactly at capacity is accepted; a Reload mid-frame must be ignored.
   task automatic test_length_max_and_ignored_reload();
      doReload();
      wrAddr.delete(); wrData.delete();
      sendByte(8'h00, 0);
      sendByte(8'h80, 0);
      tests++; if (Error !== 1'b0 || bus.ByteReady !== 1'b1) begin fails++;
         $display("FAIL len128_accept: Error=%b ByteReady=%b want 0 1", Error, bus.ByteReady); end
      doReload();
      frame = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      sendFrame(0);
      repeat (2) @(negedge Clk);
      tests++; if (wrAddr.size() != 1 || wrData[0] !== 32'hDEADBEEF || wrAddr[0] !== 32'h0) begin fails++;
         $display("FAIL ignored_reload: writes=%0d first=%h want 1 deadbeef@0", wrAddr.size(), (wrData.size() > 0) ? wrData[0] : 32'hx); end
      @(negedge Clk) Reset = 1'b0;
      @(negedge Clk) Reset = 1'b1;
   endtask

   task automatic test_zero_length();
      wrAddr.delete(); wrData.delete();
      frame = '{8'h00, 8'h00, 8'h00};
      sendFrame(0);
      repeat (2) @(negedge Clk);
      tests++; if (Done !== 1'b1 || CpuHold !== 1'b0) begin fails++; $display("FAIL len0_done: Done=%b CpuHold=%b want 1 0", Done, CpuHold); end
      tests++; if (wrAddr.size() != 0) begin fails++; $display("FAIL len0_writes: got %0d want 0", wrAddr.size()); end
      doReload();
      tests++; if (bus.ByteReady !== 1'b1 || CpuHold !== 1'b1 || Done !== 1'b0 || Error !== 1'b0) begin fails++;
         $display("FAIL reload_state: Ready=%b Hold=%b Done=%b Error=%b want 1 1 0 0", bus.ByteReady, CpuHold, Done, Error); end
   endtask

   task automatic test_reset_mid_word();
      doReload();
      frame = '{8'h00, 8'h02, 8'h20, 8'h08};
      sendFrame(0);
      @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      tests++; if (bus.ByteReady !== 1'b1 || CpuHold !== 1'b1 || Done !== 1'b0 || bus.ImemAddr !== 32'h0) begin fails++;
         $display("FAIL midreset_state: Ready=%b Hold=%b Done=%b Addr=%h want 1 1 0 0", bus.ByteReady, CpuHold, Done, bus.ImemAddr); end
      @(negedge Clk) Reset = 1'b1;
      test_good_frame("midreset", 0);
   endtask

   initial begin
      bus.ByteIn    = 8'h00;
      bus.ByteValid = 1'b0;
      repeat (3) @(negedge Clk);
      test_reset();
      @(negedge Clk) Reset = 1'b1;
      test_good_frame("good", 0);
      test_bad_checksum();
      test_length_overflow();
      test_length_max_and_ignored_reload();
      test_zero_length();
      test_good_frame("gaps", 5);
      test_reset_mid_word();
      repeat (3) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
